// File: rtl/cry_tbl_writer.sv
// CRY colour lookup table loader: takes the table as a byte stream, stores it,
// verifies the trailing checksum and serves it through a registered read port.
module cry_tbl_writer #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          dl_start,
    input  logic          dl_wr,
    input  logic [DW-1:0] dl_data,
    output logic          dl_ready,
    input  logic [AW-1:0] rd_a,
    output logic [DW-1:0] rd_z,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          tbl_valid,
    output logic [DW-1:0] csum
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [CW-1:0] idle_cnt;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          wr_en;
    logic          last_addr;
    logic          timeout_hit;
    logic [DW-1:0] sum_next;

    assign accept      = dl_wr && dl_ready;
    assign wr_en       = accept && !dl_start && (state == S_LOAD);
    assign last_addr   = (addr == {AW{1'b1}});
    assign timeout_hit = !accept && (idle_cnt == CW'(TIMEOUT - 1));
    assign sum_next    = csum + dl_data;
    assign busy        = dl_ready;

    // A start pulse overrides everything, including a byte offered in the same cycle.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state     <= S_IDLE;
            addr      <= '0;
            idle_cnt  <= '0;
            csum      <= '0;
            dl_ready  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tbl_valid <= 1'b0;
        end else if (dl_start) begin
            state     <= S_LOAD;
            addr      <= '0;
            idle_cnt  <= '0;
            csum      <= '0;
            dl_ready  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            tbl_valid <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        csum     <= sum_next;
                        idle_cnt <= '0;
                        if (last_addr) begin
                            state <= S_CHK;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end else if (timeout_hit) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        dl_ready <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                // The checksum byte only decides the outcome; it is neither stored nor summed.
                S_CHK: begin
                    if (accept) begin
                        dl_ready <= 1'b0;
                        idle_cnt <= '0;
                        if (sum_next == '0) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            tbl_valid <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        dl_ready <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[addr] <= dl_data;
        end
    end

    // Read is never gated; a same-cycle write to rd_a shows up on the following read.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            rd_z <= '0;
        end else begin
            rd_z <= mem[rd_a];
        end
    end

endmodule

// File: tb/tb_cry_tbl_writer.sv
// Directed bench for cry_tbl_writer with a short idle timeout of 16 cycles.
module tb_cry_tbl_writer;

    logic       sys_clk = 1'b0;
    logic       resetl  = 1'b0;
    logic       dl_start = 1'b0;
    logic       dl_wr    = 1'b0;
    logic [7:0] dl_data  = 8'h00;
    logic       dl_ready;
    logic [7:0] rd_a     = 8'h00;
    logic [7:0] rd_z;
    logic       busy, done, err, tbl_valid;
    logic [7:0] csum;

    int checks = 0;
    int errors = 0;

    cry_tbl_writer #(.AW(8), .DW(8), .TIMEOUT(16)) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .dl_start  (dl_start),
        .dl_wr     (dl_wr),
        .dl_data   (dl_data),
        .dl_ready  (dl_ready),
        .rd_a      (rd_a),
        .rd_z      (rd_z),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tbl_valid (tbl_valid),
        .csum      (csum)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_dl();
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (!dl_ready && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!dl_ready) begin
            errors++;
            $display("FAIL ready_wait: dl_ready=%0b after %0d cycles, required 1", dl_ready, waited);
        end
        dl_wr   = 1'b1;
        dl_data = b;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic load_table(input int gap, input logic [7:0] ck, input logic invert);
        start_dl();
        for (int i = 0; i < 256; i++) begin
            send_byte(invert ? 8'(255 - i) : 8'(i));
            for (int g = 0; g < gap; g++) tick();
        end
        send_byte(ck);
    endtask

    task automatic check_status(input string nm, input logic e_rdy, input logic e_done,
                                input logic e_err, input logic e_valid, input logic [7:0] e_csum);
        checks++;
        if ({dl_ready, busy, done, err, tbl_valid} !== {e_rdy, e_rdy, e_done, e_err, e_valid}) begin
            errors++;
            $display("FAIL %s: rdy/busy/done/err/valid=%b%b%b%b%b, required %b%b%b%b%b", nm,
                     dl_ready, busy, done, err, tbl_valid, e_rdy, e_rdy, e_done, e_err, e_valid);
        end
        checks++;
        if (csum !== e_csum) begin
            errors++;
            $display("FAIL %s_csum: csum=%02h, required %02h", nm, csum, e_csum);
        end
    endtask

    task automatic check_read(input string nm, input logic [7:0] a, input logic [7:0] exp);
        rd_a = a;
        tick();
        checks++;
        if (rd_z !== exp) begin
            errors++;
            $display("FAIL %s: rd_z[%02h]=%02h, required %02h", nm, a, rd_z, exp);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0;
        #3;
        checks++;
        if (rd_z !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdz: rd_z=%02h, required 00", rd_z);
        end
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        resetl = 1'b1;
        tick();
        check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_good_load();
        start_dl();
        check_status("load_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        check_status("in_chk", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
        send_byte(8'h80);
        check_status("good", 1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
        check_read("good_rd5a", 8'h5A, 8'h5A);
        check_read("good_rdff", 8'hFF, 8'hFF);
        check_read("good_rd00", 8'h00, 8'h00);
    endtask

    task automatic test_bad_csum();
        load_table(0, 8'h81, 1'b0);
        check_status("bad", 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    endtask

    task automatic test_sparse();
        start_dl();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i == 9) check_status("sparse_mid", 1'b1, 1'b0, 1'b0, 1'b0, 8'h2D);
            for (int g = 0; g < 6; g++) tick();
        end
        send_byte(8'h80);
        check_status("sparse", 1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
        check_read("sparse_rd80", 8'h80, 8'h80);
        check_read("sparse_rd01", 8'h01, 8'h01);
    endtask

    task automatic test_timeout();
        start_dl();
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        for (int i = 0; i < 15; i++) tick();
        check_status("tmo_before", 1'b1, 1'b0, 1'b0, 1'b0, 8'h56);
        tick();
        check_status("tmo_after", 1'b0, 1'b0, 1'b1, 1'b0, 8'h56);
    endtask

    task automatic test_restart();
        start_dl();
        for (int i = 0; i < 40; i++) send_byte(8'(i));
        dl_start = 1'b1;
        dl_wr    = 1'b1;
        dl_data  = 8'hEE;
        tick();
        dl_start = 1'b0;
        dl_wr    = 1'b0;
        check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(255 - i));
        send_byte(8'h80);
        check_status("restart_done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
        check_read("restart_rd00", 8'h00, 8'hFF);
        check_read("restart_rd01", 8'h01, 8'hFE);
        check_read("restart_rdff", 8'hFF, 8'h00);
    endtask

    task automatic test_midload_reset();
        start_dl();
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        resetl = 1'b0;
        #1;
        checks++;
        if (rd_z !== 8'h00) begin
            errors++;
            $display("FAIL midrst_rdz: rd_z=%02h, required 00", rd_z);
        end
        check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        resetl = 1'b1;
        tick();
        check_status("midrst_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_read_during_write();
        load_table(0, 8'h80, 1'b0);
        check_status("rdw_load", 1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
        start_dl();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        rd_a    = 8'h03;
        dl_wr   = 1'b1;
        dl_data = 8'hFF;
        tick();
        dl_wr   = 1'b0;
        checks++;
        if (rd_z !== 8'h03) begin
            errors++;
            $display("FAIL rdw_old: rd_z=%02h, required 03", rd_z);
        end
        tick();
        checks++;
        if (rd_z !== 8'hFF) begin
            errors++;
            $display("FAIL rdw_new: rd_z=%02h, required ff", rd_z);
        end
        check_status("rdw_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_sparse();
        test_timeout();
        test_restart();
        test_midload_reset();
        test_read_during_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
